mem_data_access: RTL and testbench
==================================

Name: mem_data_access

Overview:
MEM-stage data-access unit sitting directly downstream of the EXE stage. It captures the load/store request leaving EXE (ALU address, store data, load/store type) and drives the data-cache request/response handshake. It generates byte strobes and aligned write data, and returns the sign- or zero-extended load result to the MEM/WB path. It holds the pipeline with mem_stall while an access is outstanding and tolerates MEM_Flush at any point of the access.

Parameters:
UNCACHED_SEG, 3'b101, value of addr[31:29] that marks an access uncached (kseg1).

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
MEM_Flush  in  1  pipeline flush (exception/redirect); kills the current access
acc_valid  in  1  a load/store is leaving EXE this cycle
acc_except  in  1  EXE-detected exception on this instruction; suppresses the access
acc_is_store  in  1  1 = store, 0 = load
acc_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved (treated as word)
acc_sign  in  1  load sign-extend enable
acc_addr  in  32  EXE_ALUOut (effective address)
acc_wdata  in  32  EXE_OutB (store data, forwarded)
data_req  out  1  cache request valid
data_wr  out  1  request is a write
data_size  out  2  registered acc_size
data_addr  out  32  registered acc_addr
data_wstrb  out  4  byte strobes
data_wdata  out  32  aligned write data
data_uncached  out  1  data_addr[31:29] == UNCACHED_SEG
data_addr_ok  in  1  cache accepted the request
data_data_ok  in  1  write completed / read data valid
data_rdata  in  32  read data
load_result  out  32  extended load data (registered)
result_valid  out  1  one-cycle pulse: load_result updated / store done
mem_stall  out  1  hold EXE/MEM and earlier stages

Behaviour:
- Reset: state=IDLE; data_req=0, data_wr=0, data_size=0, data_addr=0, data_wstrb=0, data_wdata=0, load_result=0, result_valid=0. Reset mid-access goes straight to IDLE; the response to the abandoned request is not drained.
- States: IDLE, REQ, WAIT, DRAIN.
- IDLE: if acc_valid & ~acc_except & ~MEM_Flush, register addr, size, sign, is_store, strobes and aligned data, then go to REQ. If acc_except or MEM_Flush is set, there is no capture.
- REQ: data_req=1 and the request registers are held stable. On addr_ok: go to WAIT, or to DRAIN if MEM_Flush is set in the same cycle. On MEM_Flush with no addr_ok: go to IDLE; data_req is 0 the next cycle.
- WAIT: on data_data_ok, load_result=extend(rdata) (loads only; stores leave load_result unchanged), result_valid=1 for the next cycle, then go to IDLE. On MEM_Flush & ~data_ok: go to DRAIN. On MEM_Flush & data_ok: go to IDLE with no result_valid.
- DRAIN: data_data_ok goes to IDLE, rdata is discarded, and result_valid stays 0. New accesses are not captured in DRAIN.
- data_data_ok is only legal after addr_ok. In REQ it is ignored.
- mem_stall = (REQ) | (WAIT & ~data_data_ok) | (DRAIN & acc_valid). It is combinational.
- Minimum latency: capture cycle C, req in C+1 (addr_ok), data_ok in C+2, result_valid and load_result in C+3. mem_stall is high in C+1 only.
- Store strobes:
  - byte: 4'b0001 << addr[1:0], wdata={4{b[7:0]}}.
  - half: addr[1] ? 4'b1100 : 4'b0011, wdata={2{b[15:0]}}.
  - word: 4'b1111, wdata=b.
  - Loads: wstrb=0.
- Load extract: byte = rdata[8*addr[1:0]+:8], half = rdata[16*addr[1]+:16]. Extend with the sign bit when acc_sign=1, else zero. Word is passed through.
- Alignment is checked in EXE. This block never faults and uses addr[1:0] as given.

Test Plan:
1. Load byte, addr=0x8000_0003, sign=1, rdata=0x80xx_xxxx, addr_ok in C+1, data_ok in C+2 -> load_result=0xFFFF_FF80 and result_valid in C+3; mem_stall high only in C+1; data_uncached=0.
2. Store half, addr=0xA000_0002, wdata=0x1234_5678 -> data_wr=1, wstrb=4'b1100, data_wdata=0x5678_5678, data_uncached=1.
3. addr_ok withheld 3 cycles, then data_ok after 2 more cycles -> data_req and data_addr held constant; mem_stall high until the data_ok cycle; exactly one result_valid.
4. MEM_Flush in WAIT before data_ok -> DRAIN; a new acc_valid is stalled; data_ok (rdata=0xDEAD_BEEF) is discarded; load_result unchanged; the next access is captured in the cycle after DRAIN exits.
5. acc_valid with acc_except=1, and separately acc_valid with MEM_Flush in IDLE -> no data_req, mem_stall=0.
6. resetn low while in WAIT -> all outputs 0 immediately; a late data_ok is ignored; the next access completes normally.

Source files
------------

// File: rtl/mem_data_access.sv
// mem_data_access: MEM-stage load/store unit between EXE and the data cache.
// Captures the access leaving EXE, runs the cache req/addr_ok/data_ok handshake,
// builds byte strobes and aligned store data, and returns the extended load result.
// Ports:
//   clk, resetn                  clock, asynchronous active-low reset
//   MEM_Flush                    kills the current access
//   acc_*                        access request from EXE
//   data_*                       data-cache request/response channel
//   load_result, result_valid    extended load data and completion pulse
//   mem_stall                    combinational hold for EXE/MEM and earlier stages
module mem_data_access #(
    parameter logic [2:0] UNCACHED_SEG = 3'b101
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        MEM_Flush,
    input  logic        acc_valid,
    input  logic        acc_except,
    input  logic        acc_is_store,
    input  logic [1:0]  acc_size,
    input  logic        acc_sign,
    input  logic [31:0] acc_addr,
    input  logic [31:0] acc_wdata,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [3:0]  data_wstrb,
    output logic [31:0] data_wdata,
    output logic        data_uncached,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic [31:0] load_result,
    output logic        result_valid,
    output logic        mem_stall
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic        r_is_store;
    logic        r_sign;
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    logic [3:0]  r_wstrb;
    logic [31:0] r_wdata;
    logic [31:0] r_load_result;
    logic        r_result_valid;

    logic        w_capture;
    logic        w_complete;
    logic [3:0]  w_wstrb;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_ext;

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // Next-state logic; flush takes priority over completion
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_capture) w_next = S_REQ;
            S_REQ: begin
                if (data_addr_ok) w_next = MEM_Flush ? S_DRAIN : S_WAIT;
                else if (MEM_Flush) w_next = S_IDLE;
            end
            S_WAIT: begin
                if (MEM_Flush)         w_next = data_data_ok ? S_IDLE : S_DRAIN;
                else if (data_data_ok) w_next = S_IDLE;
            end
            S_DRAIN: if (data_data_ok) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        w_capture  = 1'b0;
        w_complete = 1'b0;
        mem_stall  = 1'b0;
        unique case (r_state)
            S_IDLE:  w_capture  = acc_valid & ~acc_except & ~MEM_Flush;
            S_REQ:   mem_stall  = 1'b1;
            S_WAIT: begin
                mem_stall  = ~data_data_ok;
                w_complete = data_data_ok & ~MEM_Flush;
            end
            S_DRAIN: mem_stall  = acc_valid;
            default: mem_stall  = 1'b0;
        endcase
    end

    // Store strobes and lane-replicated write data
    always_comb begin
        w_wstrb = 4'b0000;
        w_wdata = acc_wdata;
        unique case (acc_size)
            2'd0: begin
                w_wstrb = 4'b0001 << acc_addr[1:0];
                w_wdata = {4{acc_wdata[7:0]}};
            end
            2'd1: begin
                w_wstrb = acc_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{acc_wdata[15:0]}};
            end
            default: begin
                w_wstrb = 4'b1111;
                w_wdata = acc_wdata;
            end
        endcase
        if (!acc_is_store) w_wstrb = 4'b0000;
    end

    // Load lane extract and sign/zero extension
    always_comb begin
        w_byte = data_rdata[7:0];
        unique case (r_addr[1:0])
            2'd0: w_byte = data_rdata[7:0];
            2'd1: w_byte = data_rdata[15:8];
            2'd2: w_byte = data_rdata[23:16];
            2'd3: w_byte = data_rdata[31:24];
            default: w_byte = data_rdata[7:0];
        endcase
        w_half = r_addr[1] ? data_rdata[31:16] : data_rdata[15:0];
        unique case (r_size)
            2'd0:    w_load_ext = {{24{r_sign & w_byte[7]}}, w_byte};
            2'd1:    w_load_ext = {{16{r_sign & w_half[15]}}, w_half};
            default: w_load_ext = data_rdata;
        endcase
    end

    // Request capture and result registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_is_store     <= 1'b0;
            r_sign         <= 1'b0;
            r_size         <= 2'd0;
            r_addr         <= 32'd0;
            r_wstrb        <= 4'd0;
            r_wdata        <= 32'd0;
            r_load_result  <= 32'd0;
            r_result_valid <= 1'b0;
        end else begin
            if (w_capture) begin
                r_is_store <= acc_is_store;
                r_sign     <= acc_sign;
                r_size     <= acc_size;
                r_addr     <= acc_addr;
                r_wstrb    <= w_wstrb;
                r_wdata    <= w_wdata;
            end
            r_result_valid <= w_complete;
            if (w_complete && !r_is_store) r_load_result <= w_load_ext;
        end
    end

    assign data_req      = (r_state == S_REQ);
    assign data_wr       = r_is_store;
    assign data_size     = r_size;
    assign data_addr     = r_addr;
    assign data_wstrb    = r_wstrb;
    assign data_wdata    = r_wdata;
    assign data_uncached = (r_addr[31:29] == UNCACHED_SEG);
    assign load_result   = r_load_result;
    assign result_valid  = r_result_valid;

endmodule

// File: tb/tb_mem_data_access.sv
module tb_mem_data_access;

    logic        clk;
    logic        resetn;
    logic        MEM_Flush;
    logic        acc_valid;
    logic        acc_except;
    logic        acc_is_store;
    logic [1:0]  acc_size;
    logic        acc_sign;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_uncached;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic [31:0] load_result;
    logic        result_valid;
    logic        mem_stall;

    int checks = 0;
    int errors = 0;

    mem_data_access dut (
        .clk(clk), .resetn(resetn), .MEM_Flush(MEM_Flush),
        .acc_valid(acc_valid), .acc_except(acc_except), .acc_is_store(acc_is_store),
        .acc_size(acc_size), .acc_sign(acc_sign), .acc_addr(acc_addr), .acc_wdata(acc_wdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_uncached(data_uncached),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .load_result(load_result), .result_valid(result_valid), .mem_stall(mem_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are checked just after each falling edge.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        MEM_Flush = 0; acc_valid = 0; acc_except = 0; acc_is_store = 0;
        acc_size = 0; acc_sign = 0; acc_addr = 0; acc_wdata = 0;
        data_addr_ok = 0; data_data_ok = 0; data_rdata = 0;
    endtask

    task automatic set_acc(input logic st, input logic [1:0] sz, input logic sg,
                           input logic [31:0] a, input logic [31:0] wd);
        acc_valid = 1; acc_is_store = st; acc_size = sz; acc_sign = sg;
        acc_addr = a; acc_wdata = wd;
    endtask

    task automatic test_reset();
        idle_inputs();
        resetn = 0;
        cyc(); cyc(); #1;
        checks++; if ({data_req, data_wr, data_size, data_wstrb, result_valid, mem_stall} !== 10'd0) begin errors++; $display("FAIL reset_ctrl got %b exp 0", {data_req, data_wr, data_size, data_wstrb, result_valid, mem_stall}); end
        checks++; if ({data_addr, data_wdata, load_result} !== 96'd0) begin errors++; $display("FAIL reset_data got %h exp 0", {data_addr, data_wdata, load_result}); end
        cyc(); resetn = 1;
    endtask

    task automatic test_load_byte();
        cyc(); set_acc(0, 2'd0, 1, 32'h8000_0003, 32'h0); #1;
        checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL lb_stall_c got %b exp 0", mem_stall); end
        cyc(); acc_valid = 0; data_addr_ok = 1; #1;
        checks++; if (mem_stall !== 1'b1 || data_req !== 1'b1) begin errors++; $display("FAIL lb_c1 stall/req got %b%b exp 11", mem_stall, data_req); end
        checks++; if (data_addr !== 32'h8000_0003 || data_wr !== 1'b0 || data_wstrb !== 4'b0000 || data_uncached !== 1'b0) begin errors++; $display("FAIL lb_c1_req got addr %h wr %b strb %b unc %b exp 80000003 0 0000 0", data_addr, data_wr, data_wstrb, data_uncached); end
        cyc(); data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'h8012_3456; #1;
        checks++; if (mem_stall !== 1'b0 || data_req !== 1'b0 || result_valid !== 1'b0) begin errors++; $display("FAIL lb_c2 stall/req/rv got %b%b%b exp 000", mem_stall, data_req, result_valid); end
        cyc(); data_data_ok = 0; #1;
        checks++; if (result_valid !== 1'b1 || load_result !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_c3 rv %b res %h exp 1 ffffff80", result_valid, load_result); end
        checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL lb_c3_stall got %b exp 0", mem_stall); end
        cyc(); #1;
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL lb_c4_rv got %b exp 0", result_valid); end
    endtask

    task automatic test_store_half();
        cyc(); set_acc(1, 2'd1, 0, 32'hA000_0002, 32'h1234_5678);
        cyc(); idle_inputs(); data_addr_ok = 1; #1;
        checks++; if (data_req !== 1'b1 || data_wr !== 1'b1 || data_size !== 2'd1) begin errors++; $display("FAIL sh_req got req %b wr %b size %0d exp 1 1 1", data_req, data_wr, data_size); end
        checks++; if (data_wstrb !== 4'b1100 || data_wdata !== 32'h5678_5678) begin errors++; $display("FAIL sh_data got strb %b wdata %h exp 1100 56785678", data_wstrb, data_wdata); end
        checks++; if (data_uncached !== 1'b1) begin errors++; $display("FAIL sh_uncached got %b exp 1", data_uncached); end
        cyc(); data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'h0BAD_0BAD;
        cyc(); data_data_ok = 0; #1;
        checks++; if (result_valid !== 1'b1 || load_result !== 32'hFFFF_FF80) begin errors++; $display("FAIL sh_done rv %b res %h exp 1 ffffff80", result_valid, load_result); end
    endtask

    task automatic test_slow_handshake();
        int pulses = 0;
        int stall_bad = 0;
        int hold_bad = 0;
        cyc(); set_acc(0, 2'd2, 0, 32'h0000_1000, 32'h0);
        cyc(); acc_valid = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (data_req !== 1'b1 || data_addr !== 32'h0000_1000) hold_bad++;
            if (mem_stall !== 1'b1) stall_bad++;
            if (result_valid) pulses++;
            cyc();
        end
        data_addr_ok = 1; #1;
        if (data_req !== 1'b1 || data_addr !== 32'h0000_1000) hold_bad++;
        if (mem_stall !== 1'b1) stall_bad++;
        cyc(); data_addr_ok = 0; #1;
        if (mem_stall !== 1'b1 || data_req !== 1'b0) stall_bad++;
        cyc(); data_data_ok = 1; data_rdata = 32'hCAFE_F00D; #1;
        if (mem_stall !== 1'b0) stall_bad++;
        checks++; if (hold_bad != 0) begin errors++; $display("FAIL slow_hold got %0d bad cycles exp 0", hold_bad); end
        checks++; if (stall_bad != 0) begin errors++; $display("FAIL slow_stall got %0d bad cycles exp 0", stall_bad); end
        cyc(); data_data_ok = 0; #1;
        checks++; if (load_result !== 32'hCAFE_F00D) begin errors++; $display("FAIL slow_result got %h exp cafef00d", load_result); end
        for (int i = 0; i < 4; i++) begin
            if (result_valid) pulses++;
            cyc(); #1;
        end
        checks++; if (pulses != 1) begin errors++; $display("FAIL slow_pulses got %0d exp 1", pulses); end
    endtask

    task automatic test_flush_drain();
        cyc(); set_acc(0, 2'd1, 1, 32'h0000_0002, 32'h0);
        cyc(); acc_valid = 0; data_addr_ok = 1;
        cyc(); data_addr_ok = 0; MEM_Flush = 1; #1;
        checks++; if (mem_stall !== 1'b1) begin errors++; $display("FAIL fl_wait_stall got %b exp 1", mem_stall); end
        cyc(); MEM_Flush = 0; set_acc(0, 2'd0, 0, 32'h0000_0001, 32'h0); #1;
        checks++; if (mem_stall !== 1'b1 || data_req !== 1'b0) begin errors++; $display("FAIL fl_drain stall/req got %b%b exp 10", mem_stall, data_req); end
        cyc(); data_data_ok = 1; data_rdata = 32'hDEAD_BEEF; #1;
        checks++; if (mem_stall !== 1'b1) begin errors++; $display("FAIL fl_drain_ok_stall got %b exp 1", mem_stall); end
        cyc(); data_data_ok = 0; #1;
        checks++; if (mem_stall !== 1'b0 || result_valid !== 1'b0 || load_result !== 32'hCAFE_F00D) begin errors++; $display("FAIL fl_discard stall %b rv %b res %h exp 0 0 cafef00d", mem_stall, result_valid, load_result); end
        cyc(); acc_valid = 0; data_addr_ok = 1; #1;
        checks++; if (data_req !== 1'b1 || data_addr !== 32'h0000_0001) begin errors++; $display("FAIL fl_next_req got req %b addr %h exp 1 00000001", data_req, data_addr); end
        cyc(); data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'h0000_AB00;
        cyc(); data_data_ok = 0; #1;
        checks++; if (result_valid !== 1'b1 || load_result !== 32'h0000_00AB) begin errors++; $display("FAIL fl_next_res rv %b res %h exp 1 000000ab", result_valid, load_result); end
    endtask

    task automatic test_suppress();
        cyc(); set_acc(0, 2'd2, 0, 32'h0000_0040, 32'h0); acc_except = 1; #1;
        checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL exc_stall got %b exp 0", mem_stall); end
        cyc(); idle_inputs(); #1;
        checks++; if (data_req !== 1'b0 || mem_stall !== 1'b0) begin errors++; $display("FAIL exc_req req %b stall %b exp 0 0", data_req, mem_stall); end
        cyc(); set_acc(1, 2'd2, 0, 32'h0000_0044, 32'h1); MEM_Flush = 1; #1;
        checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL flidle_stall got %b exp 0", mem_stall); end
        cyc(); idle_inputs(); #1;
        checks++; if (data_req !== 1'b0 || mem_stall !== 1'b0) begin errors++; $display("FAIL flidle_req req %b stall %b exp 0 0", data_req, mem_stall); end
    endtask

    task automatic test_reset_mid_access();
        cyc(); set_acc(0, 2'd2, 0, 32'h0000_0010, 32'h0);
        cyc(); acc_valid = 0; data_addr_ok = 1;
        cyc(); data_addr_ok = 0; resetn = 0; #1;
        checks++; if ({data_req, data_wr, data_size, data_wstrb, result_valid, mem_stall} !== 10'd0 || {data_addr, data_wdata, load_result} !== 96'd0) begin errors++; $display("FAIL rst_mid got ctrl %b data %h exp 0", {data_req, data_wr, data_size, data_wstrb, result_valid, mem_stall}, {data_addr, data_wdata, load_result}); end
        cyc(); resetn = 1; data_data_ok = 1; data_rdata = 32'h1111_1111; #1;
        checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL rst_late_stall got %b exp 0", mem_stall); end
        cyc(); data_data_ok = 0; #1;
        checks++; if (result_valid !== 1'b0 || load_result !== 32'h0 || data_req !== 1'b0) begin errors++; $display("FAIL rst_late rv %b res %h req %b exp 0 0 0", result_valid, load_result, data_req); end
        cyc(); set_acc(1, 2'd0, 0, 32'h0000_0005, 32'h0000_00AB);
        cyc(); idle_inputs(); data_addr_ok = 1; #1;
        checks++; if (data_req !== 1'b1 || data_wstrb !== 4'b0010 || data_wdata !== 32'hABAB_ABAB) begin errors++; $display("FAIL rst_next_req req %b strb %b wdata %h exp 1 0010 abababab", data_req, data_wstrb, data_wdata); end
        cyc(); data_addr_ok = 0; data_data_ok = 1;
        cyc(); data_data_ok = 0; #1;
        checks++; if (result_valid !== 1'b1 || load_result !== 32'h0) begin errors++; $display("FAIL rst_next_done rv %b res %h exp 1 0", result_valid, load_result); end
    endtask

    initial begin
        test_reset();
        test_load_byte();
        test_store_half();
        test_slow_handshake();
        test_flush_drain();
        test_suppress();
        test_reset_mid_access();
        cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
